mem_tid_arbiter: RTL and testbench

- Shares the single cache-to-memory request channel of the write-through data-cache subsystem among several requesters: icache refill, dcache miss, dcache write buffer and PTW.
- Allocates a transaction ID of MemTidWidth bits to each issued request.
- Tracks which requester owns each outstanding ID and routes each memory response back to that owner.
- Sits between the cache controllers and the NoC/AXI adapter.

---
 rtl/mem_tid_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_tid_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_tid_arbiter.sv
// Round-robin arbiter that shares the memory request channel and routes responses by transaction ID.
// Define MEM_TID_ARB_PERF_CNT_EN to add the stall and issue performance counters.
module mem_tid_arbiter #(
    parameter int NrReq       = 3,
    parameter int AddrWidth   = 64,
    parameter int MemTidWidth = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NrReq-1:0]           req_valid_i,
    output logic [NrReq-1:0]           req_ready_o,
    input  logic [NrReq*AddrWidth-1:0] req_addr_i,
    input  logic [NrReq-1:0]           req_we_i,
    output logic                       mem_req_valid_o,
    input  logic                       mem_req_ready_i,
    output logic [AddrWidth-1:0]       mem_req_addr_o,
    output logic                       mem_req_we_o,
    output logic [MemTidWidth-1:0]     mem_req_tid_o,
    input  logic                       mem_rsp_valid_i,
    input  logic [MemTidWidth-1:0]     mem_rsp_tid_i,
    output logic [NrReq-1:0]           rsp_valid_o,
    output logic [MemTidWidth:0]       outstanding_o,
`ifdef MEM_TID_ARB_PERF_CNT_EN
    output logic [31:0]                stall_cnt_o,
    output logic [31:0]                issue_cnt_o,
`endif
    output logic                       err_o
);

    localparam int NrTid   = 2 ** MemTidWidth;
    localparam int ReqIdxW = (NrReq > 1) ? $clog2(NrReq) : 1;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_e;

    state_e                 state_q;
    logic [NrTid-1:0]       busy_q;
    logic [NrTid-1:0]       busy_nxt;
    logic [ReqIdxW-1:0]     owner_q [NrTid];
    logic [ReqIdxW-1:0]     ptr_q;
    logic [ReqIdxW-1:0]     ptr_nxt;
    logic                   valid_q;
    logic [AddrWidth-1:0]   addr_q;
    logic                   we_q;
    logic [MemTidWidth-1:0] tid_q;
    logic [MemTidWidth:0]   cnt_q;
    logic                   err_q;

    logic                   win_found;
    logic [ReqIdxW-1:0]     win_idx;
    logic                   free_found;
    logic [MemTidWidth-1:0] free_tid;
    logic                   accept;
    logic                   rsp_hit;
    logic [ReqIdxW-1:0]     rsp_owner;
    logic                   handshake;

    // First valid requester at or after the pointer, wrapping at NrReq.
    always_comb begin
        int k;
        win_found = 1'b0;
        win_idx   = '0;
        k         = 0;
        for (int i = 0; i < NrReq; i++) begin
            k = (int'(ptr_q) + i) % NrReq;
            if (!win_found && req_valid_i[k]) begin
                win_found = 1'b1;
                win_idx   = ReqIdxW'(k);
            end
        end
    end

    always_comb begin
        free_found = 1'b0;
        free_tid   = '0;
        for (int t = NrTid - 1; t >= 0; t--) begin
            if (!busy_q[t]) begin
                free_found = 1'b1;
                free_tid   = MemTidWidth'(t);
            end
        end
    end

    assign accept    = (state_q == IDLE) && win_found && free_found;
    assign rsp_hit   = mem_rsp_valid_i && busy_q[mem_rsp_tid_i];
    assign rsp_owner = owner_q[mem_rsp_tid_i];
    assign handshake = valid_q && mem_req_ready_i;

    assign ptr_nxt = (win_idx == ReqIdxW'(NrReq - 1)) ? '0 : win_idx + 1'b1;

    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[win_idx] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        if (rsp_hit) begin
            rsp_valid_o[rsp_owner] = 1'b1;
        end
    end

    // Allocation only picks IDs free at cycle start, so it never collides with the freed ID.
    always_comb begin
        busy_nxt = busy_q;
        if (rsp_hit) begin
            busy_nxt[mem_rsp_tid_i] = 1'b0;
        end
        if (accept) begin
            busy_nxt[free_tid] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            busy_q  <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            tid_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q <= busy_nxt;
            cnt_q  <= cnt_q + (MemTidWidth+1)'(accept)
                            - (MemTidWidth+1)'(rsp_hit);
            if (mem_rsp_valid_i && !busy_q[mem_rsp_tid_i]) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= req_addr_i[int'(win_idx)*AddrWidth +: AddrWidth];
                        we_q    <= req_we_i[win_idx];
                        tid_q   <= free_tid;
                        ptr_q   <= ptr_nxt;
                        valid_q <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int t = 0; t < NrTid; t++) begin
                owner_q[t] <= '0;
            end
        end else if (accept) begin
            owner_q[free_tid] <= win_idx;
        end
    end

    assign mem_req_valid_o = valid_q;
    assign mem_req_addr_o  = addr_q;
    assign mem_req_we_o    = we_q;
    assign mem_req_tid_o   = tid_q;
    assign outstanding_o   = cnt_q;
    assign err_o           = err_q;

`ifdef MEM_TID_ARB_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] issue_q;
    logic        stall;

    assign stall = (|req_valid_i) && !free_found;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
            issue_q <= '0;
        end else begin
            if (stall && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (handshake && (issue_q != '1)) begin
                issue_q <= issue_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_q;
    assign issue_cnt_o = issue_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_mem_tid_arbiter.sv
// Scoreboard bench for mem_tid_arbiter: issued requests are checked against
// entries queued when each grant is expected.
module tb_mem_tid_arbiter;

    typedef struct packed {
        logic [63:0] addr;
        logic        we;
        logic [1:0]  tid;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [2:0]   req_valid;
    logic [2:0]   req_ready;
    logic [191:0] req_addr;
    logic [2:0]   req_we;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [63:0]  mem_req_addr;
    logic         mem_req_we;
    logic [1:0]   mem_req_tid;
    logic         mem_rsp_valid;
    logic [1:0]   mem_rsp_tid;
    logic [2:0]   rsp_valid;
    logic [2:0]   outstanding;
    logic         err;
`ifdef MEM_TID_ARB_PERF_CNT_EN
    logic [31:0]  stall_cnt;
    logic [31:0]  issue_cnt;
`endif

    int   total = 0;
    int   bad   = 0;
    int   pops  = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    mem_tid_arbiter dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_addr_i     (req_addr),
        .req_we_i       (req_we),
        .mem_req_valid_o(mem_req_valid),
        .mem_req_ready_i(mem_req_ready),
        .mem_req_addr_o (mem_req_addr),
        .mem_req_we_o   (mem_req_we),
        .mem_req_tid_o  (mem_req_tid),
        .mem_rsp_valid_i(mem_rsp_valid),
        .mem_rsp_tid_i  (mem_rsp_tid),
        .rsp_valid_o    (rsp_valid),
        .outstanding_o  (outstanding),
`ifdef MEM_TID_ARB_PERF_CNT_EN
        .stall_cnt_o    (stall_cnt),
        .issue_cnt_o    (issue_cnt),
`endif
        .err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] addr_of(input int k);
        return 64'h8000_0000 + 64'(k) * 64'h100 + 64'h18;
    endfunction

    function automatic logic we_of(input int k);
        return (k == 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input int w, input int tid);
        exp_t e;
        chk(tag, 64'(req_ready), 64'(3'b001 << w));
        e.addr = addr_of(w);
        e.we   = we_of(w);
        e.tid  = 2'(tid);
        exp_q.push_back(e);
    endtask

    // Issued requests are compared when the handshake is seen.
    always @(negedge clk) begin
        if (!rst && mem_req_valid && mem_req_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexp_issue", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("iss_addr", mem_req_addr, mon_e.addr);
                chk("iss_we", 64'(mem_req_we), 64'(mon_e.we));
                chk("iss_tid", 64'(mem_req_tid), 64'(mon_e.tid));
                pops++;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Four grants with all requesters valid: winners 0,1,2,0 and tids 0..3.
    task automatic grant4();
        int w;
        req_valid     = 3'b111;
        mem_req_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            w = (g == 3) ? 0 : g;
            @(negedge clk);
            expect_grant("g4_ready", w, g);
            nxt();
            @(negedge clk);
            chk("g4_valid", 64'(mem_req_valid), 64'd1);
            chk("g4_ready_iss", 64'(req_ready), 64'd0);
            nxt();
        end
    endtask

    initial begin
        rst           = 1'b1;
        req_valid     = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_tid   = '0;
        for (int k = 0; k < 3; k++) begin
            req_addr[k*64 +: 64] = addr_of(k);
            req_we[k]            = we_of(k);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp", 64'(rsp_valid), 64'd0);
        chk("rst_outst", 64'(outstanding), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_addr", mem_req_addr, 64'd0);
        chk("rst_tid", 64'(mem_req_tid), 64'd0);
        nxt();

        // Round-robin fill of all IDs.
        grant4();
        @(negedge clk);
        chk("full_ready", 64'(req_ready), 64'd0);
        chk("full_outst", 64'(outstanding), 64'd4);
        nxt();

        // Response on tid 2 frees it; requester 1 takes it a cycle later.
        req_valid = 3'b010;
        @(negedge clk);
        chk("stall_ready", 64'(req_ready), 64'd0);
        nxt();
        mem_rsp_valid = 1'b1;
        mem_rsp_tid   = 2'd2;
        @(negedge clk);
        chk("rsp2_route", 64'(rsp_valid), 64'b100);
        chk("rsp2_ready", 64'(req_ready), 64'd0);
        nxt();
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("t2_outst", 64'(outstanding), 64'd3);
        expect_grant("t2_ready", 1, 2);
        nxt();
        req_valid = 3'b000;
        @(negedge clk);
        chk("t2_outst_full", 64'(outstanding), 64'd4);
        nxt();

        // Backpressure: request stays stable while the source address moves.
        mem_rsp_valid = 1'b1;
        mem_rsp_tid   = 2'd0;
        @(negedge clk);
        chk("rsp0_route", 64'(rsp_valid), 64'b001);
        nxt();
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
        req_valid     = 3'b100;
        @(negedge clk);
        expect_grant("t3_ready", 2, 0);
        nxt();
        req_valid           = 3'b111;
        req_addr[128 +: 64] = 64'hDEAD_BEEF_0000_0000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_valid", 64'(mem_req_valid), 64'd1);
            chk("hold_addr", mem_req_addr, addr_of(2));
            chk("hold_we", 64'(mem_req_we), 64'(we_of(2)));
            chk("hold_tid", 64'(mem_req_tid), 64'd0);
            chk("hold_ready", 64'(req_ready), 64'd0);
            nxt();
        end
        mem_req_ready = 1'b1;
        req_valid     = 3'b000;
        @(negedge clk);
        nxt();
        req_addr[128 +: 64] = addr_of(2);

        // Response for an idle ID sets the sticky error.
        do_reset();
        mem_rsp_valid = 1'b1;
        mem_rsp_tid   = 2'd3;
        @(negedge clk);
        chk("err_pre", 64'(err), 64'd0);
        chk("err_rsp", 64'(rsp_valid), 64'd0);
        nxt();
        mem_rsp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("err_sticky", 64'(err), 64'd1);
            nxt();
        end

        // Reset while a request is held in ISSUE with two IDs busy.
        req_valid     = 3'b111;
        mem_req_ready = 1'b1;
        @(negedge clk);
        expect_grant("t5_g0", 0, 0);
        nxt();
        @(negedge clk);
        nxt();
        @(negedge clk);
        expect_grant("t5_g1", 1, 1);
        nxt();
        mem_req_ready = 1'b0;
        req_valid     = 3'b000;
        @(negedge clk);
        chk("t5_outst2", 64'(outstanding), 64'd2);
        chk("t5_held", 64'(mem_req_valid), 64'd1);
        nxt();
        do_reset();
        @(negedge clk);
        chk("t5_valid0", 64'(mem_req_valid), 64'd0);
        chk("t5_outst0", 64'(outstanding), 64'd0);
        chk("t5_err0", 64'(err), 64'd0);
        nxt();
        req_valid     = 3'b111;
        mem_req_ready = 1'b1;
        @(negedge clk);
        expect_grant("t5_first", 0, 0);
        nxt();
        req_valid = 3'b000;
        @(negedge clk);
        nxt();

`ifdef MEM_TID_ARB_PERF_CNT_EN
        do_reset();
        @(negedge clk);
        chk("perf_stall0", 64'(stall_cnt), 64'd0);
        chk("perf_issue0", 64'(issue_cnt), 64'd0);
        nxt();
        grant4();
        nxt();
        nxt();
        req_valid = 3'b000;
        @(negedge clk);
        chk("perf_stall", 64'(stall_cnt), 64'd3);
        chk("perf_issue", 64'(issue_cnt), 64'd4);
        nxt();
        chk("pop_count", 64'(pops), 64'd12);
`else
        chk("pop_count", 64'(pops), 64'd8);
`endif
        chk("q_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
